// File: rtl/pipeFlow_pkg.sv
// Shared definitions for the pipeline arbiter slice.
//   arb_state_e : arbiter FSM states (ARB = searching, HOLD = stalled winner latched)
//   PIPE_DEPTH  : latency of the shared pipeline; MAX_OUT must be at least this
package pipeFlow_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int PIPE_DEPTH = 5;

endpackage

// File: rtl/tag_fifo.sv
// Tag FIFO: remembers which requester owns each beat in flight through the
// in-order pipeline. The head entry is presented combinationally so the
// return path can route a beat in the same cycle it leaves the pipeline.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   push, push_data : enqueue a tag (ignored when full)
//   pop             : dequeue the head tag (ignored when empty)
//   head            : tag at the head of the queue
//   full, empty     : occupancy flags
//   count           : number of tags stored, 0..DEPTH
module tag_fifo
    import pipeFlow_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage is never reset: stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/pipe_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one in-order
// pipeline and routes each returning beat back to the requester that issued
// it, using a FIFO of owner tags.
// Ports:
//   clk_i, reset_ni          : clock, asynchronous active-low reset
//   req_val/req_valid/req_rdy: per-requester issue interface
//   to_pipe_*                : pipeline input interface
//   from_pipe_*              : pipeline output interface
//   rsp_val/rsp_valid/rsp_rdy: return interface (shared data, one-hot valid)
//   cfg_en                   : requester enable mask
//   outstanding              : beats currently in flight
//   err_o                    : sticky flag, pipeline produced a beat with no tag
module pipe_arbiter
    import pipeFlow_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 5,
    parameter int MAX_OUT = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_ni,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_val,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_rdy,
    output logic [DATA_W-1:0]                to_pipe_val,
    output logic                             to_pipe_valid,
    input  logic                             to_pipe_rdy,
    input  logic [DATA_W-1:0]                from_pipe_val,
    input  logic                             from_pipe_valid,
    output logic                             from_pipe_rdy,
    output logic [DATA_W-1:0]                rsp_val,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_rdy,
    input  logic [NUM_REQ-1:0]               cfg_en,
    output logic [$clog2(MAX_OUT):0]         outstanding,
    output logic                             err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e        state_reg, state_next;
    logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]  hold_idx_reg, hold_idx_next;
    logic [DATA_W-1:0] hold_data_reg, hold_data_next;
    logic              err_reg;

    logic [NUM_REQ-1:0] eligible;
    logic               search_hit;
    logic [IDX_W-1:0]   search_idx;
    logic               grant_any;
    logic [IDX_W-1:0]   win_idx;
    logic [DATA_W-1:0]  pipe_data;

    logic               tag_full;
    logic               tag_empty;
    logic [IDX_W-1:0]   tag_head;
    logic               push_xfer;
    logic               pop_xfer;

    assign eligible = req_valid & cfg_en;

    // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin : rr_search
        int cand;
        search_hit = 1'b0;
        search_idx = '0;
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!search_hit && eligible[IDX_W'(cand)]) begin
                search_hit = 1'b1;
                search_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        hold_idx_next  = hold_idx_reg;
        hold_data_next = hold_data_reg;
        grant_any      = 1'b0;
        win_idx        = search_idx;
        pipe_data      = req_val[search_idx];
        case (state_reg)
            ARB: begin
                // A full tag FIFO suppresses the grant entirely, so a stall
                // never starts while there is no room for its tag.
                grant_any = search_hit & ~tag_full;
                win_idx   = search_idx;
                pipe_data = req_val[search_idx];
                if (grant_any && !to_pipe_rdy) begin
                    state_next     = HOLD;
                    hold_idx_next  = search_idx;
                    hold_data_next = req_val[search_idx];
                end
            end
            HOLD: begin
                // Winner and data come from the latch, so requester-side
                // changes (valid, data, cfg_en) cannot disturb the offer.
                grant_any = ~tag_full;
                win_idx   = hold_idx_reg;
                pipe_data = hold_data_reg;
                if (grant_any && to_pipe_rdy) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
        if (grant_any && to_pipe_rdy) begin
            rr_ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg     <= ARB;
            rr_ptr_reg    <= '0;
            hold_idx_reg  <= '0;
            hold_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            hold_idx_reg  <= hold_idx_next;
            hold_data_reg <= hold_data_next;
        end
    end

    // Handshake outputs are qualified with reset_ni so they read low for the
    // whole time reset is asserted, not just after the next clock edge.
    assign to_pipe_valid = grant_any & reset_ni;
    assign to_pipe_val   = pipe_data;
    assign push_xfer     = to_pipe_valid & to_pipe_rdy;

    // With no tag pending, the pipeline beat is accepted and dropped so the
    // pipeline cannot lock up; err_o records the event.
    assign from_pipe_rdy = reset_ni & (tag_empty | rsp_rdy[tag_head]);
    assign pop_xfer      = from_pipe_valid & from_pipe_rdy & ~tag_empty;
    assign rsp_val       = from_pipe_val;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
        assign req_rdy[gi]   = reset_ni & grant_any & to_pipe_rdy
                               & (win_idx == IDX_W'(gi));
        assign rsp_valid[gi] = reset_ni & from_pipe_valid & ~tag_empty
                               & (tag_head == IDX_W'(gi));
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            err_reg <= 1'b0;
        end else if (from_pipe_valid && tag_empty) begin
            err_reg <= 1'b1;
        end
    end

    assign err_o = err_reg;

    tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .push      (push_xfer),
        .push_data (win_idx),
        .pop       (pop_xfer),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (outstanding)
    );

endmodule

// File: tb/tb_pipe_arbiter.sv
// Self-checking bench for pipe_arbiter. Each scenario task drives the DUT and
// pushes the beats it expects to be issued onto a scoreboard queue; returned
// beats are popped from the queue and compared when driven back through the
// pipeline output port (the bench plays an identity pipeline).
module tb_pipe_arbiter;
    import pipeFlow_pkg::*;

    localparam int NR = 4;
    localparam int DW = 5;
    localparam int MO = 8;

    typedef struct packed {
        logic [1:0]    owner;
        logic [DW-1:0] data;
    } beat_t;

    logic                    clk_i = 1'b0;
    logic                    reset_ni = 1'b0;
    logic [NR-1:0][DW-1:0]   req_val = '0;
    logic [NR-1:0]           req_valid = '0;
    logic [NR-1:0]           req_rdy;
    logic [DW-1:0]           to_pipe_val;
    logic                    to_pipe_valid;
    logic                    to_pipe_rdy = 1'b1;
    logic [DW-1:0]           from_pipe_val = '0;
    logic                    from_pipe_valid = 1'b0;
    logic                    from_pipe_rdy;
    logic [DW-1:0]           rsp_val;
    logic [NR-1:0]           rsp_valid;
    logic [NR-1:0]           rsp_rdy = 4'hF;
    logic [NR-1:0]           cfg_en = 4'hF;
    logic [$clog2(MO):0]     outstanding;
    logic                    err_o;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk_i = ~clk_i;

    pipe_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .MAX_OUT (MO)
    ) dut (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .req_val         (req_val),
        .req_valid       (req_valid),
        .req_rdy         (req_rdy),
        .to_pipe_val     (to_pipe_val),
        .to_pipe_valid   (to_pipe_valid),
        .to_pipe_rdy     (to_pipe_rdy),
        .from_pipe_val   (from_pipe_val),
        .from_pipe_valid (from_pipe_valid),
        .from_pipe_rdy   (from_pipe_rdy),
        .rsp_val         (rsp_val),
        .rsp_valid       (rsp_valid),
        .rsp_rdy         (rsp_rdy),
        .cfg_en          (cfg_en),
        .outstanding     (outstanding),
        .err_o           (err_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Return the oldest expected beat through the pipeline output and check
    // that it is routed to its owner with its data intact.
    task automatic return_beat();
        beat_t b;
        logic [NR-1:0] exp_onehot;
        b = exp_q.pop_front();
        exp_onehot = 4'b0001 << b.owner;
        from_pipe_valid = 1'b1;
        from_pipe_val   = b.data;
        rsp_rdy         = 4'hF;
        #1;
        checks++;
        if (rsp_valid !== exp_onehot) begin
            errors++;
            $display("FAIL rsp_valid got %b exp %b", rsp_valid, exp_onehot);
        end
        checks++;
        if (rsp_val !== b.data) begin
            errors++;
            $display("FAIL rsp_val got %h exp %h", rsp_val, b.data);
        end
        checks++;
        if (from_pipe_rdy !== 1'b1) begin
            errors++;
            $display("FAIL from_pipe_rdy got %b exp 1", from_pipe_rdy);
        end
        $display("return owner %0d data %h rsp_valid %b", b.owner, rsp_val, rsp_valid);
        step();
        from_pipe_valid = 1'b0;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) return_beat();
        #1;
        checks++;
        if (outstanding !== 4'd0) begin
            errors++;
            $display("FAIL drain_outstanding got %0d exp 0", outstanding);
        end
    endtask

    task automatic test_reset();
        step();
        req_valid       = 4'hF;
        req_val[0]      = 5'h11;
        from_pipe_valid = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_req_rdy got %b exp 0000", req_rdy); end
        checks++;
        if (to_pipe_valid !== 1'b0) begin errors++; $display("FAIL reset_to_pipe_valid got %b exp 0", to_pipe_valid); end
        checks++;
        if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_o); end
        checks++;
        if (from_pipe_rdy !== 1'b0) begin errors++; $display("FAIL reset_from_pipe_rdy got %b exp 0", from_pipe_rdy); end
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
        #1;
        reset_ni = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin errors++; $display("FAIL release_grant got %b exp 0001", req_rdy); end
        checks++;
        if (to_pipe_val !== 5'h11) begin errors++; $display("FAIL release_val got %h exp 11", to_pipe_val); end
        $display("reset released, first grant %b", req_rdy);
        req_valid       = '0;
        from_pipe_valid = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0]    exp_owner;
        logic [DW-1:0] exp_data;
        req_valid   = 4'hF;
        cfg_en      = 4'hF;
        to_pipe_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < NR; i++) req_val[i] = DW'(i * 7 + c);
            exp_owner = 2'(c % 4);
            exp_data  = DW'(int'(exp_owner) * 7 + c);
            #1;
            checks++;
            if (req_rdy !== (4'b0001 << exp_owner)) begin
                errors++;
                $display("FAIL rr_grant cycle %0d got %b exp owner %0d", c, req_rdy, exp_owner);
            end
            checks++;
            if (to_pipe_val !== exp_data) begin
                errors++;
                $display("FAIL rr_val cycle %0d got %h exp %h", c, to_pipe_val, exp_data);
            end
            $display("issue owner %0d data %h", exp_owner, exp_data);
            exp_q.push_back('{owner: exp_owner, data: exp_data});
            step();
        end
        req_valid = '0;
        #1;
        checks++;
        if (outstanding !== 4'd5) begin errors++; $display("FAIL rr_outstanding got %0d exp 5", outstanding); end
        drain();
        step();
    endtask

    task automatic test_stall();
        // rr_ptr is 1 here; with 2 and 3 requesting, 2 wins.
        req_valid   = 4'b1100;
        req_val[2]  = 5'h13;
        req_val[3]  = 5'h1E;
        to_pipe_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (to_pipe_valid !== 1'b1 || to_pipe_val !== 5'h13) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got valid %b val %h exp 1 13", c, to_pipe_valid, to_pipe_val);
            end
            checks++;
            if (req_rdy !== 4'b0000) begin
                errors++;
                $display("FAIL stall_req_rdy cycle %0d got %b exp 0000", c, req_rdy);
            end
            step();
            // Disturb the requester side while held; the offer must not move.
            req_val[2] = 5'h04;
            req_valid  = 4'b1000;
            cfg_en     = 4'b1011;
        end
        to_pipe_rdy = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0100 || to_pipe_val !== 5'h13) begin
            errors++;
            $display("FAIL stall_accept got rdy %b val %h exp 0100 13", req_rdy, to_pipe_val);
        end
        $display("issue owner 2 data 13 after stall");
        exp_q.push_back('{owner: 2'd2, data: 5'h13});
        step();
        cfg_en = 4'hF;
        #1;
        checks++;
        if (req_rdy !== 4'b1000 || to_pipe_val !== 5'h1E) begin
            errors++;
            $display("FAIL stall_next got rdy %b val %h exp 1000 1e", req_rdy, to_pipe_val);
        end
        $display("issue owner 3 data 1e");
        exp_q.push_back('{owner: 2'd3, data: 5'h1E});
        step();
        req_valid = '0;
        drain();
        step();
    endtask

    task automatic test_return_routing();
        req_valid  = 4'b0010;
        req_val[1] = 5'h0A;
        #1;
        checks++;
        if (req_rdy !== 4'b0010) begin errors++; $display("FAIL route_grant1 got %b exp 0010", req_rdy); end
        exp_q.push_back('{owner: 2'd1, data: 5'h0A});
        step();
        req_valid  = 4'b1000;
        req_val[3] = 5'h15;
        #1;
        checks++;
        if (req_rdy !== 4'b1000) begin errors++; $display("FAIL route_grant3 got %b exp 1000", req_rdy); end
        exp_q.push_back('{owner: 2'd3, data: 5'h15});
        step();
        req_valid = '0;
        repeat (PIPE_DEPTH - 2) step();
        // Owner not ready: the head beat must be held in the pipeline.
        from_pipe_valid = 1'b1;
        from_pipe_val   = 5'h0A;
        rsp_rdy         = 4'b1101;
        #1;
        checks++;
        if (from_pipe_rdy !== 1'b0 || rsp_valid !== 4'b0010) begin
            errors++;
            $display("FAIL route_backpressure got rdy %b rsp_valid %b exp 0 0010", from_pipe_rdy, rsp_valid);
        end
        step();
        checks++;
        if (outstanding !== 4'd2) begin errors++; $display("FAIL route_held got %0d exp 2", outstanding); end
        from_pipe_valid = 1'b0;
        rsp_rdy         = 4'hF;
        drain();
        step();
    endtask

    task automatic test_full_fifo();
        logic [1:0]    exp_owner;
        logic [DW-1:0] exp_data;
        // rr_ptr is 0 here.
        req_valid = 4'hF;
        rsp_rdy   = 4'h0;
        for (int k = 0; k < MO; k++) begin
            for (int i = 0; i < NR; i++) req_val[i] = DW'(3 * k + i);
            exp_owner = 2'(k % 4);
            exp_data  = DW'(3 * k + int'(exp_owner));
            #1;
            checks++;
            if (req_rdy !== (4'b0001 << exp_owner)) begin
                errors++;
                $display("FAIL full_fill beat %0d got %b exp owner %0d", k, req_rdy, exp_owner);
            end
            exp_q.push_back('{owner: exp_owner, data: exp_data});
            step();
        end
        #1;
        checks++;
        if (outstanding !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", outstanding); end
        checks++;
        if (to_pipe_valid !== 1'b0 || req_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL full_block got valid %b rdy %b exp 0 0000", to_pipe_valid, req_rdy);
        end
        step();
        return_beat();
        #1;
        checks++;
        if (outstanding !== 4'd7) begin errors++; $display("FAIL full_pop got %0d exp 7", outstanding); end
        checks++;
        if (to_pipe_valid !== 1'b1 || req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL full_resume got valid %b rdy %b exp 1 0001", to_pipe_valid, req_rdy);
        end
        // Push and pop in the same cycle leave the count unchanged.
        exp_q.push_back('{owner: 2'd0, data: DW'(21)});
        return_beat();
        req_valid = '0;
        #1;
        checks++;
        if (outstanding !== 4'd7) begin errors++; $display("FAIL full_pushpop got %0d exp 7", outstanding); end
        drain();
        step();
    endtask

    task automatic test_mask();
        logic [1:0] owners [4];
        // rr_ptr is 1 here; with only 0 and 2 enabled they alternate from 2.
        owners = '{2'd2, 2'd0, 2'd2, 2'd0};
        cfg_en    = 4'b0101;
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NR; i++) req_val[i] = DW'(16 + k + i);
            #1;
            checks++;
            if (req_rdy !== (4'b0001 << owners[k])) begin
                errors++;
                $display("FAIL mask_grant beat %0d got %b exp owner %0d", k, req_rdy, owners[k]);
            end
            exp_q.push_back('{owner: owners[k], data: DW'(16 + k + int'(owners[k]))});
            step();
        end
        req_valid = '0;
        cfg_en    = 4'hF;
        drain();
        step();
    endtask

    task automatic test_error_reset();
        from_pipe_valid = 1'b1;
        from_pipe_val   = 5'h1F;
        rsp_rdy         = 4'h0;
        #1;
        checks++;
        if (from_pipe_rdy !== 1'b1 || rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL err_drop got rdy %b rsp_valid %b exp 1 0000", from_pipe_rdy, rsp_valid);
        end
        step();
        from_pipe_valid = 1'b0;
        rsp_rdy         = 4'hF;
        step();
        step();
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err_o); end
        // rr_ptr is 1 here: three beats go to 1, 2, 3 and stay in flight.
        req_valid = 4'hF;
        for (int k = 1; k < 4; k++) begin
            #1;
            checks++;
            if (req_rdy !== (4'b0001 << k)) begin
                errors++;
                $display("FAIL err_issue got %b exp owner %0d", req_rdy, k);
            end
            step();
        end
        req_valid = '0;
        #1;
        checks++;
        if (outstanding !== 4'd3 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_prereset got out %0d err %b exp 3 1", outstanding, err_o);
        end
        reset_ni = 1'b0;
        #1;
        checks++;
        if (outstanding !== 4'd0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got out %0d err %b exp 0 0", outstanding, err_o);
        end
        exp_q.delete();
        step();
        reset_ni  = 1'b1;
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_rdy !== 4'b0001) begin errors++; $display("FAIL rr_after_reset got %b exp 0001", req_rdy); end
        req_valid = '0;
        step();
        checks++;
        if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_flush got %0d exp 0", outstanding); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_return_routing();
        test_full_fifo();
        test_mask();
        test_error_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_arbiter.md
PIPE_ARBITER -- requirements
Module: pipe_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the pipeline, range 2..8.
REQ-002 Parameter DATA_W, default 5: beat width, equal to the pipeline data width.
REQ-003 Parameter MAX_OUT, default 8: maximum beats in flight; power of 2 and at least the pipeline depth (5).
REQ-004 Port clk_i, input, 1: the single clock; all state is on its rising edge.
REQ-005 Port reset_ni, input, 1: asynchronous, active-low reset.
REQ-006 Port req_val, input, NUM_REQ x DATA_W: per-requester beat data.
REQ-007 Port req_valid, input, NUM_REQ: per-requester beat valid.
REQ-008 Port req_rdy, output, NUM_REQ: per-requester beat accepted.
REQ-009 Port to_pipe_val, output, DATA_W: beat driven into the pipeline input.
REQ-010 Port to_pipe_valid, output, 1: pipeline input valid.
REQ-011 Port to_pipe_rdy, input, 1: pipeline input ready.
REQ-012 Port from_pipe_val, input, DATA_W: beat leaving the pipeline.
REQ-013 Port from_pipe_valid, input, 1: pipeline output valid.
REQ-014 Port from_pipe_rdy, output, 1: pipeline output ready.
REQ-015 Port rsp_val, output, DATA_W: returned beat, shared by all requesters.
REQ-016 Port rsp_valid, output, NUM_REQ: one-hot return valid to the owning requester.
REQ-017 Port rsp_rdy, input, NUM_REQ: per-requester return ready.
REQ-018 Port cfg_en, input, NUM_REQ: requester enable mask; a disabled requester is never granted.
REQ-019 Port outstanding, output, clog2(MAX_OUT)+1: beats currently in flight.
REQ-020 Port err_o, output, 1: sticky error flag for a pipeline output beat with no tag.

Function
REQ-021 Transfers: a transfer occurs on any interface in a cycle where its valid and rdy are both high; to_pipe_valid SHALL NOT depend on to_pipe_rdy.
REQ-022 Arbiter states: ARB and HOLD.
REQ-023 ARB state: grant the first requester with req_valid and cfg_en high, searching round-robin from rr_ptr.
REQ-024 ARB, stalled: if a granted beat is not accepted (to_pipe_rdy low), go to HOLD with the winner latched.
REQ-025 HOLD state: keep the latched grant, with to_pipe_valid high and to_pipe_val stable, until the beat is accepted, then return to ARB; cfg_en changes are ignored while in HOLD.
REQ-026 rr_ptr update: after each accepted beat, rr_ptr becomes (winner+1) mod NUM_REQ; otherwise it is unchanged.
REQ-027 Request side: req_rdy[i] = grant[i] AND to_pipe_rdy AND NOT tag_full; to_pipe_valid = any grant AND NOT tag_full; to_pipe_val = the winner's req_val.
REQ-028 Tag FIFO: depth MAX_OUT; push the winner index on each to_pipe transfer; pop on each from_pipe transfer; the pipeline is in-order.
REQ-029 Return side: rsp_val = from_pipe_val; rsp_valid[head] = from_pipe_valid; from_pipe_rdy = rsp_rdy[head]; zero added latency.
REQ-030 FIFO full: when outstanding equals MAX_OUT, to_pipe_valid is held low and no grant is issued.
REQ-031 Simultaneous push and pop: outstanding is unchanged, and a full FIFO still accepts the pop.
REQ-032 FIFO empty with from_pipe_valid high: from_pipe_rdy is high (drop the beat), all rsp_valid are low, and err_o sets until reset.
REQ-033 Requester drop: if a requester drops req_valid while granted in HOLD, the beat is still issued from the latched data; this counts as a protocol violation and requires no recovery.

Reset
REQ-034 While reset_ni is low: state ARB, rr_ptr 0, FIFO empty, outstanding 0, err_o 0, req_rdy 0, to_pipe_valid 0, rsp_valid 0, from_pipe_rdy 0.
REQ-035 Reset mid-operation discards all in-flight tags; the pipeline is reset in the same domain.
REQ-036 The first grant after reset release is issued in the cycle following deassertion.

Structure
REQ-037 Shared package pipeFlow_pkg holds the arb_state_e typedef (ARB, HOLD) and the PIPE_DEPTH=5 constant.
REQ-038 The tag FIFO is a sub-module named tag_fifo (parameters WIDTH and DEPTH; ports push, pop, full, empty, count).
REQ-039 The arbiter and handshake logic live in pipe_arbiter; it holds no data storage beyond the HOLD latch.

Verification
REQ-040 Scenario, round-robin: all 4 requesters valid, to_pipe_rdy=1, cfg_en=4'hF -> grants 0,1,2,3,0 on consecutive cycles.
REQ-041 Scenario, stall: req 2 granted, to_pipe_rdy=0 for 3 cycles -> HOLD, to_pipe_val stable, req_rdy[2] low; the beat is accepted on cycle 4 and the next grant goes to req 3.
REQ-042 Scenario, return routing: req1 sends 5'h0A, then req3 sends 5'h15 -> after the pipeline latency, rsp_valid=4'b0010 with 5'h0A, then rsp_valid=4'b1000 with 5'h15.
REQ-043 Scenario, full FIFO: from_pipe_rdy path blocked (rsp_rdy=0), 8 beats issued -> outstanding=8, to_pipe_valid=0; one return frees a slot and the next grant resumes.
REQ-044 Scenario, mask: cfg_en=4'b0101 with all valid -> only requesters 0 and 2 are granted, alternating.
REQ-045 Scenario, error and reset: from_pipe_valid pulsed with the FIFO empty -> err_o=1 and held; a reset_ni pulse mid-stream clears err_o and outstanding to 0 asynchronously.
